uart_rx_frame_ctrl: RTL and testbench

Frame controller placed directly after the UART byte receiver. It consumes one-cycle byte strobes, hunts for a start-of-frame delimiter, parses a length-prefixed frame, buffers the payload, and checks an 8-bit checksum. Only checksum-verified payloads are released to the baseband processor, over a valid/ready stream. Malformed, stalled or overrun frames are dropped and reported with a one-cycle error pulse and code.

---
 rtl/uart_rx_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
//   Frame controller behind the UART byte receiver. Hunts for the SOF
//   delimiter, parses a length-prefixed frame (SOF, LEN, payload, CHK),
//   buffers the payload and releases it over a valid/ready stream only when
//   (LEN + sum(payload) + CHK) mod 256 == 0. Dropped frames and bytes raise a
//   one-cycle error pulse with a code.
// Ports
//   clk, rst_n           : clock, synchronous active-low reset
//   rx_valid_i/rx_byte_i : one-cycle received-byte strobe and byte
//   payload_*            : payload stream (data, valid, last, ready)
//   frame_ok_o           : pulse, frame passed its checks
//   frame_err_o          : pulse, frame/byte dropped; err_code_o qualifies it
//   err_code_o           : 00 OVERRUN, 01 LEN_BAD, 10 CHK_BAD, 11 TIMEOUT
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SOF         = 8'h7E,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned TIMEOUT_CYC = 208340
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_byte_i,
  output logic [7:0] payload_data_o,
  output logic       payload_valid_o,
  output logic       payload_last_o,
  input  logic       payload_ready_i,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]    MAX_LEN9 = 9'(MAX_LEN);

  localparam logic [1:0] ERR_OVERRUN = 2'b00;
  localparam logic [1:0] ERR_LEN_BAD = 2'b01;
  localparam logic [1:0] ERR_CHK_BAD = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_DATA, ST_CHK, ST_OUT} state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]     sum_q, sum_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           ok_q, ok_d;
  logic           err_q, err_d;
  logic [1:0]     code_q, code_d;
  logic           buf_we;
  logic [7:0]     sum_add;
  logic           in_frame;
  logic           last;
  logic [7:0]     buf_q [MAX_LEN];

  assign sum_add  = sum_q + rx_byte_i;
  assign in_frame = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);
  assign last     = (rd_ptr_q == len_q - LW'(1));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sum_d    = sum_q;
    timer_d  = '0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    buf_we   = 1'b0;

    unique case (state_q)
      ST_HUNT: begin
        if (rx_valid_i && rx_byte_i == SOF) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid_i) begin
          if (rx_byte_i == 8'h00 || {1'b0, rx_byte_i} > MAX_LEN9) begin
            err_d   = 1'b1;
            code_d  = ERR_LEN_BAD;
            state_d = ST_HUNT;
          end else begin
            len_d    = LW'(rx_byte_i);
            sum_d    = rx_byte_i;
            wr_ptr_d = '0;
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (rx_valid_i) begin
          buf_we   = 1'b1;
          sum_d    = sum_add;
          wr_ptr_d = wr_ptr_q + LW'(1);
          if (wr_ptr_q == len_q - LW'(1)) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (rx_valid_i) begin
          if (sum_add == 8'h00) begin
            ok_d     = 1'b1;
            rd_ptr_d = '0;
            state_d  = ST_OUT;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHK_BAD;
            state_d = ST_HUNT;
          end
        end
      end
      ST_OUT: begin
        // Bytes arriving while draining are lost; the stream is untouched.
        if (rx_valid_i) begin
          err_d  = 1'b1;
          code_d = ERR_OVERRUN;
        end
        if (payload_ready_i) begin
          rd_ptr_d = rd_ptr_q + LW'(1);
          if (last) state_d = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Gap timer: a byte always wins over an expiring timer.
    if (in_frame && !rx_valid_i) begin
      if (timer_q == TMO_LAST) begin
        err_d   = 1'b1;
        code_d  = ERR_TIMEOUT;
        state_d = ST_HUNT;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_HUNT;
      len_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sum_q    <= '0;
      timer_q  <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sum_q    <= sum_d;
      timer_q  <= timer_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      code_q   <= code_d;
    end
  end

  // Payload storage is never cleared; only OUT ever exposes it.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[wr_ptr_q[AW-1:0]] <= rx_byte_i;
  end

  assign payload_valid_o = (state_q == ST_OUT);
  assign payload_data_o  = payload_valid_o ? buf_q[rd_ptr_q[AW-1:0]] : '0;
  assign payload_last_o  = payload_valid_o && last;
  assign frame_ok_o      = ok_q;
  assign frame_err_o     = err_q;
  assign err_code_o      = code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;
  localparam int MAXL = 64;
  localparam int TMO  = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       ready = 1'b1;
  logic [7:0] payload_data_o;
  logic       payload_valid_o;
  logic       payload_last_o;
  logic       frame_ok_o;
  logic       frame_err_o;
  logic [1:0] err_code_o;

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .SOF(8'h7E),
    .MAX_LEN(MAXL),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_valid_i(rx_valid),
    .rx_byte_i(rx_byte),
    .payload_data_o(payload_data_o),
    .payload_valid_o(payload_valid_o),
    .payload_last_o(payload_last_o),
    .payload_ready_i(ready),
    .frame_ok_o(frame_ok_o),
    .frame_err_o(frame_err_o),
    .err_code_o(err_code_o)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } pay_t;

  int         tests = 0;
  int         fails = 0;
  pay_t       exp_pay[$];
  int         exp_ok = 0;
  logic [1:0] exp_err[$];
  int         xfers = 0;
  int         ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Ready driver
  initial begin
    logic [5:0] pat;
    int pi;
    pat = 6'b101001;
    pi = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: ready = 1'b1;
        1: ready = 1'($urandom % 2);
        2: begin ready = pat[pi]; pi = (pi + 1) % 6; end
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic pv, pr, pl;
    logic [7:0] pd;
    pay_t p;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("stall_valid", 32'(payload_valid_o), 32'd1);
          check("stall_data", 32'(payload_data_o), 32'(pd));
          check("stall_last", 32'(payload_last_o), 32'(pl));
        end
        if (payload_valid_o && ready) begin
          xfers++;
          if (exp_pay.size() == 0) flag("payload_extra");
          else begin
            p = exp_pay.pop_front();
            check("payload_data", 32'(payload_data_o), 32'(p.d));
            check("payload_last", 32'(payload_last_o), 32'(p.l));
          end
        end
        if (frame_ok_o) begin
          if (exp_ok == 0) flag("frame_ok_extra");
          else begin exp_ok--; tests++; end
        end
        if (frame_err_o) begin
          if (exp_err.size() == 0) flag("frame_err_extra");
          else check("err_code", 32'(err_code_o), 32'(exp_err.pop_front()));
        end
        pv = payload_valid_o; pr = ready; pd = payload_data_o; pl = payload_last_o;
      end
    end
  end

  // Frame-level reference model
  task automatic model_frame(input logic [7:0] f[$]);
    int len, s;
    pay_t p;
    len = int'(f[1]);
    if (len == 0 || len > MAXL) begin
      exp_err.push_back(2'b01);
      return;
    end
    s = 0;
    for (int i = 1; i <= len + 2; i++) s += int'(f[i]);
    if (s % 256 == 0) begin
      exp_ok++;
      for (int i = 0; i < len; i++) begin
        p.d = f[2 + i];
        p.l = (i == len - 1);
        exp_pay.push_back(p);
      end
    end else begin
      exp_err.push_back(2'b10);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int gap_max);
    model_frame(f);
    foreach (f[i]) begin
      send_byte(f[i]);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_pay.size() != 0 || exp_ok != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) flag("drain_timeout");
  endtask

  function automatic logic [7:0] chk_of(input logic [7:0] f[$]);
    int s;
    s = 0;
    for (int i = 1; i < f.size(); i++) s += int'(f[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  initial begin
    logic [7:0] f[$];
    logic [7:0] d0;
    int early, x0, len, kind;

    // Reset
    rst_n = 1'b0;
    idle(3);
    check("rst_valid", 32'(payload_valid_o), 32'd0);
    check("rst_data", 32'(payload_data_o), 32'd0);
    check("rst_last", 32'(payload_last_o), 32'd0);
    check("rst_pulses", 32'({frame_ok_o, frame_err_o, err_code_o}), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Good frame, ready held high: latency and throughput
    ready_mode = 0;
    idle(1);
    f = '{8'h7E, 8'h03, 8'h41, 8'h42, 8'h43, 8'h37};
    model_frame(f);
    foreach (f[i]) send_byte(f[i]);
    check("good_ok", 32'(frame_ok_o), 32'd1);
    check("good_v0", 32'({payload_valid_o, payload_last_o, payload_data_o}), 32'h241);
    idle(1);
    check("good_v1", 32'({payload_valid_o, payload_last_o, payload_data_o}), 32'h242);
    idle(1);
    check("good_v2", 32'({payload_valid_o, payload_last_o, payload_data_o}), 32'h343);
    idle(1);
    check("good_done", 32'(payload_valid_o), 32'd0);
    wait_drain(100);

    // Backpressure
    ready_mode = 2;
    x0 = xfers;
    send_frame(f, 0);
    wait_drain(200);
    check("bp_xfers", 32'(xfers - x0), 32'd3);
    ready_mode = 0;
    idle(2);

    // Bad checksum then good frame
    send_frame('{8'h7E, 8'h02, 8'h10, 8'h20, 8'h00}, 0);
    idle(3);
    send_frame(f, 1);
    wait_drain(200);

    // Bad lengths, junk ignored
    send_frame('{8'h7E, 8'h00}, 0);
    send_frame('{8'h7E, 8'h41}, 0);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_frame(f, 0);
    wait_drain(200);

    // Timeout exactly TMO cycles after the last strobe
    exp_err.push_back(2'b11);
    send_byte(8'h7E);
    send_byte(8'h05);
    send_byte(8'h11);
    early = 0;
    for (int k = 1; k <= TMO; k++) begin
      idle(1);
      if (k < TMO && frame_err_o) early++;
      if (k == TMO) check("tmo_pulse", 32'({frame_err_o, err_code_o}), 32'h7);
    end
    check("tmo_early", 32'(early), 32'd0);
    idle(2);

    // Byte on the final timer cycle continues the frame
    f = '{8'h7E, 8'h02, 8'h11, 8'h22};
    f.push_back(chk_of(f));
    model_frame(f);
    send_byte(f[0]);
    send_byte(f[1]);
    send_byte(f[2]);
    idle(TMO - 1);
    send_byte(f[3]);
    send_byte(f[4]);
    wait_drain(200);

    // Overrun during a stalled OUT
    ready_mode = 3;
    idle(1);
    f = '{8'h7E, 8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    f.push_back(chk_of(f));
    send_frame(f, 0);
    idle(2);
    d0 = payload_data_o;
    exp_err.push_back(2'b00);
    send_byte(8'h99);
    check("ovr_pulse", 32'({frame_err_o, err_code_o}), 32'h4);
    check("ovr_hold", 32'({payload_valid_o, payload_data_o}), 32'({1'b1, d0}));
    ready_mode = 0;
    wait_drain(200);

    // Reset in the middle of DATA
    send_byte(8'h7E);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    idle(1);
    check("rst_mid", 32'({payload_valid_o, payload_last_o, payload_data_o, frame_ok_o, frame_err_o, err_code_o}), 32'd0);
    rst_n = 1'b1;
    idle(1);
    f = '{8'h7E, 8'h03, 8'h41, 8'h42, 8'h43, 8'h37};
    send_frame(f, 0);
    wait_drain(200);

    // Randomized frames
    ready_mode = 1;
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom_range(0, 125)));
      kind = $urandom_range(0, 7);
      if (kind == 0) len = 0;
      else if (kind == 1) len = $urandom_range(MAXL + 1, 255);
      else if (kind < 5) len = $urandom_range(1, 8);
      else len = $urandom_range(1, MAXL);
      f = '{8'h7E, 8'(len)};
      if (len >= 1 && len <= MAXL) begin
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
        f.push_back(chk_of(f));
        if ($urandom_range(0, 3) == 0) f[f.size() - 1] = f[f.size() - 1] + 8'($urandom_range(1, 255));
      end
      send_frame(f, 3);
      wait_drain(2000);
    end

    ready_mode = 0;
    idle(5);
    check("end_pay_q", 32'(exp_pay.size()), 32'd0);
    check("end_ok_q", 32'(exp_ok), 32'd0);
    check("end_err_q", 32'(exp_err.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
